// File: rtl/cdb_arbiter_pkg.sv
// Shared types and sizing for the CDB writeback arbiter.
package cdb_arbiter_pkg;

   localparam int unsigned NUM_CDB_REQ     = 3;
   localparam int unsigned CDB_QUEUE_DEPTH = 2;
   localparam int unsigned CDB_IDX_W       = $clog2(NUM_CDB_REQ);

   typedef logic [5:0]  phys_reg_tag_t;
   typedef logic [31:0] word_t;
   typedef logic [3:0]  ROB_index_t;

   typedef enum logic [1:0] {
      CDB_ALU_0,
      CDB_ALU_1,
      CDB_LQ
   } cdb_source_t;

   typedef struct packed {
      phys_reg_tag_t phys_reg_tag;
      word_t         data;
      ROB_index_t    ROB_index;
   } cdb_entry_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Requester-side completion bus and CDB broadcast bundle.
interface cdb_arbiter_if;
   import cdb_arbiter_pkg::*;

   logic          [NUM_CDB_REQ-1:0] req_valid;
   logic          [NUM_CDB_REQ-1:0] req_ready;
   phys_reg_tag_t [NUM_CDB_REQ-1:0] req_phys_reg_tag;
   word_t         [NUM_CDB_REQ-1:0] req_data;
   ROB_index_t    [NUM_CDB_REQ-1:0] req_ROB_index;

   logic          cdb_valid;
   phys_reg_tag_t cdb_phys_reg_tag;
   word_t         cdb_data;
   ROB_index_t    cdb_ROB_index;
   cdb_source_t   cdb_source;

   modport master (
      output req_valid, req_phys_reg_tag, req_data, req_ROB_index,
      input  req_ready, cdb_valid, cdb_phys_reg_tag, cdb_data, cdb_ROB_index, cdb_source
   );

   modport slave (
      input  req_valid, req_phys_reg_tag, req_data, req_ROB_index,
      output req_ready, cdb_valid, cdb_phys_reg_tag, cdb_data, cdb_ROB_index, cdb_source
   );

endinterface

// File: rtl/cdb_req_queue.sv
// Small per-requester FIFO of CDB completions; flush empties it.
module cdb_req_queue
   import cdb_arbiter_pkg::*;
#(
   parameter int unsigned Depth = CDB_QUEUE_DEPTH
) (
   input  logic       CLK,
   input  logic       nRST,
   input  logic       flush,
   input  logic       enq,
   input  cdb_entry_t enq_data,
   input  logic       deq,
   output cdb_entry_t head,
   output logic       empty,
   output logic       full
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   cdb_entry_t      r_mem [Depth];
   logic [PtrW-1:0] r_head;
   logic [PtrW-1:0] r_tail;
   logic [CntW-1:0] r_count;
   logic            w_push;
   logic            w_pop;

   function automatic logic [PtrW-1:0] wrap_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   assign w_push = enq && !full && !flush;
   assign w_pop  = deq && !empty && !flush;
   assign head   = r_mem[r_head];
   assign empty  = (r_count == '0);
   assign full   = (r_count == CntW'(Depth));

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_tail <= wrap_inc(r_tail);
         if (w_pop)  r_head <= wrap_inc(r_head);
         if (w_push && !w_pop)      r_count <= r_count + CntW'(1);
         else if (w_pop && !w_push) r_count <= r_count - CntW'(1);
      end
   end

   // Storage needs no reset: an entry is only read once count covers it.
   always_ff @(posedge CLK) begin
      if (w_push) r_mem[r_tail] <= enq_data;
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB writeback arbiter with per-requester queues and registered broadcast.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
(
   input  logic          CLK,
   input  logic          nRST,
   input  logic          flush,
   cdb_arbiter_if.slave  bus
);

   logic       [NUM_CDB_REQ-1:0] w_empty;
   logic       [NUM_CDB_REQ-1:0] w_full;
   logic       [NUM_CDB_REQ-1:0] w_deq;
   cdb_entry_t [NUM_CDB_REQ-1:0] w_enq_data;
   cdb_entry_t [NUM_CDB_REQ-1:0] w_head;

   logic                 w_gnt_valid;
   logic [CDB_IDX_W-1:0] w_gnt_idx;
   logic [CDB_IDX_W-1:0] w_rr_next;

   logic [CDB_IDX_W-1:0] r_rr_ptr;
   logic                 r_cdb_valid;
   cdb_entry_t           r_cdb_entry;
   cdb_source_t          r_cdb_source;

   for (genvar g = 0; g < NUM_CDB_REQ; g++) begin : g_queue
      assign w_enq_data[g] = '{phys_reg_tag: bus.req_phys_reg_tag[g],
                               data:         bus.req_data[g],
                               ROB_index:    bus.req_ROB_index[g]};
      assign w_deq[g]      = w_gnt_valid && (w_gnt_idx == CDB_IDX_W'(g));

      cdb_req_queue #(
         .Depth (CDB_QUEUE_DEPTH)
      ) u_queue (
         .CLK      (CLK),
         .nRST     (nRST),
         .flush    (flush),
         .enq      (bus.req_valid[g]),
         .enq_data (w_enq_data[g]),
         .deq      (w_deq[g]),
         .head     (w_head[g]),
         .empty    (w_empty[g]),
         .full     (w_full[g])
      );
   end

   // Scan from r_rr_ptr, wrapping; the first non-empty queue wins.
   always_comb begin
      int unsigned idx;
      idx         = 0;
      w_gnt_valid = 1'b0;
      w_gnt_idx   = '0;
      for (int unsigned k = 0; k < NUM_CDB_REQ; k++) begin
         idx = (32'(r_rr_ptr) + k) % NUM_CDB_REQ;
         if (!w_gnt_valid && !w_empty[idx]) begin
            w_gnt_valid = 1'b1;
            w_gnt_idx   = CDB_IDX_W'(idx);
         end
      end
      w_rr_next = (w_gnt_idx == CDB_IDX_W'(NUM_CDB_REQ - 1)) ? '0 : w_gnt_idx + CDB_IDX_W'(1);
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_rr_ptr     <= '0;
         r_cdb_valid  <= 1'b0;
         r_cdb_entry  <= '0;
         r_cdb_source <= CDB_ALU_0;
      end else if (flush) begin
         r_cdb_valid  <= 1'b0;
      end else if (w_gnt_valid) begin
         r_rr_ptr     <= w_rr_next;
         r_cdb_valid  <= 1'b1;
         r_cdb_entry  <= w_head[w_gnt_idx];
         r_cdb_source <= cdb_source_t'(w_gnt_idx);
      end else begin
         r_cdb_valid  <= 1'b0;
      end
   end

   // Ready comes from registered counts only; a same-cycle pop does not free a slot.
   assign bus.req_ready        = ~w_full;
   assign bus.cdb_valid        = r_cdb_valid;
   assign bus.cdb_phys_reg_tag = r_cdb_entry.phys_reg_tag;
   assign bus.cdb_data         = r_cdb_entry.data;
   assign bus.cdb_ROB_index    = r_cdb_entry.ROB_index;
   assign bus.cdb_source       = r_cdb_source;

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus (CDB) writeback arbiter. It buffers completions from ALU_0, ALU_1 and LQ in per-requester 2-deep queues. Each cycle it selects one buffered completion round-robin and broadcasts it on a registered CDB. The CDB drives the phys reg file write port, the phys reg ready table, RS/LSQ wakeup and ROB complete. A flush input discards all buffered and in-flight completions on ROB restore/revert.

## Interface
Parameters:
- NUM_CDB_REQ, 3: requester count; index 0 = ALU_0, 1 = ALU_1, 2 = LQ.
- CDB_QUEUE_DEPTH, 2: entries per requester queue.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- nRST  in  1  reset, asynchronous, active-low.
- flush  in  1  ROB restore/revert; discard all pending work.
- req_valid  in  [NUM_CDB_REQ]  requester i presents a completion.
- req_ready  out  [NUM_CDB_REQ]  queue i can accept.
- req_phys_reg_tag  in  [NUM_CDB_REQ] x phys_reg_tag_t  destination phys reg.
- req_data  in  [NUM_CDB_REQ] x word_t  result value.
- req_ROB_index  in  [NUM_CDB_REQ] x ROB_index_t  completing ROB entry.
- cdb_valid  out  1  broadcast valid this cycle.
- cdb_phys_reg_tag  out  phys_reg_tag_t  broadcast tag.
- cdb_data  out  word_t  broadcast value.
- cdb_ROB_index  out  ROB_index_t  broadcast ROB index.
- cdb_source  out  cdb_source_t  requester that won the broadcast.

## Operation
- **Enqueue:** at a posedge with req_valid[i] && req_ready[i] && !flush, the request is written to the tail of queue i.
- **Ready rule:** req_ready[i] = (count[i] < CDB_QUEUE_DEPTH). It is computed from registered state only and does not count a same-cycle dequeue. A full queue therefore stays not-ready for the cycle it drains.
- **Arbitration (combinational):** scan requesters starting at rr_ptr, wrapping modulo NUM_CDB_REQ. The first non-empty queue wins and is popped at the edge.
- **Pointer update:**
  - On a grant to i: rr_ptr <= (i+1) mod NUM_CDB_REQ.
  - With no grant: rr_ptr holds.
  - flush does not change rr_ptr.
- **Output register:** the winning head entry is loaded into the cdb_* registers, with cdb_valid <= 1 and cdb_source <= i. With no winner, cdb_valid <= 0 and the payload registers hold their value.
- **Ordering:** within one requester, completions broadcast in FIFO order. No ordering is guaranteed across requesters.
- **flush:**
  - All queue counts and pointers clear.
  - cdb_valid <= 0 at that edge.
  - Same-cycle enqueues and the arbitration pop are discarded.
  - Because cdb_valid is registered, an entry already broadcast in the flush cycle still appears; consumers qualify it with their own flush logic.
- **Simultaneous events:** enqueue and dequeue on the same non-full queue in the same cycle leave count unchanged. Head and tail pointers both advance, wrapping at CDB_QUEUE_DEPTH.

## Timing
- **Reset values (nRST low, async):**
  - cdb_valid=0; cdb_phys_reg_tag=0; cdb_data=0; cdb_ROB_index=0; cdb_source=CDB_ALU_0.
  - rr_ptr=0; all counts 0, so req_ready = all 1s.
- **Latency:** a request accepted at edge N is broadcast, at the earliest, in the cycle after edge N+1. Minimum latency is 2 edges; there is no bypass.
- **Throughput:** 1 broadcast per cycle total; each requester gets at least 1 grant in every NUM_CDB_REQ consecutive cycles while its queue is non-empty.
- **Handshake:** req_ready depends only on registered state, so a requester may sample it at any point in the cycle.
- **Mid-operation reset:** reset deassertion returns the block to its reset state; no partial entries survive.

## Structure
- Add to core_types_pkg:
  - parameters NUM_CDB_REQ=3 and CDB_QUEUE_DEPTH=2;
  - typedef enum logic [1:0] cdb_source_t {CDB_ALU_0, CDB_ALU_1, CDB_LQ};
  - typedef struct packed cdb_entry_t {phys_reg_tag_t phys_reg_tag; word_t data; ROB_index_t ROB_index;}.
- Sub-module cdb_req_queue: a 2-deep FIFO of cdb_entry_t.
  - Ports: CLK, nRST, flush, enq, enq_data, deq, head, empty, full.
  - Instantiated NUM_CDB_REQ times.
- The arbiter, rr_ptr and output register live in cdb_arbiter.

## Test plan
- **Single request:** reset, then ALU_1 enqueues tag 5, data 0xDEADBEEF, ROB 3 at edge 1 → cycle after edge 2: cdb_valid=1, tag 5, data 0xDEADBEEF, ROB 3, source CDB_ALU_1; rr_ptr=2; cdb_valid=0 the next cycle.
- **Round-robin fairness:** all three requesters enqueue one entry each at edge 1 with rr_ptr=0 → broadcasts follow ALU_0, ALU_1, LQ on consecutive cycles, then cdb_valid=0.
- **Backpressure:** LQ enqueues on 3 consecutive edges while ALU_0 keeps its queue non-empty → req_ready[2] is 0 after the 2nd LQ enqueue; the 3rd request is not accepted until a pop.
  - LQ entries drain in FIFO order, interleaved with ALU_0.
- **Flush:** with 2 entries queued in each queue, assert flush for 1 cycle → cdb_valid=0 the following cycle, all req_ready=1, no stale broadcast afterwards, rr_ptr unchanged.
- **Flush with enqueue:** ALU_0 asserts req_valid in the flush cycle → entry dropped, no broadcast.
- **Async reset mid-stream:** drop nRST while queues are non-empty → outputs go to reset values immediately, without waiting for CLK; queues are empty after release.
